// File: rtl/register_port_pkg.sv
// Shared definitions for the register-file port arbiter: FSM encoding and
// hold-counter limits.
package register_port_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  localparam int MAX_HOLD_LIMIT = 15;
  localparam int HOLD_W         = $clog2(MAX_HOLD_LIMIT + 1);

  // Keeps an out-of-range MAX_HOLD from producing a zero or overflowing limit.
  function automatic int clamp_hold(input int h);
    if (h < 1) return 1;
    if (h > MAX_HOLD_LIMIT) return MAX_HOLD_LIMIT;
    return h;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational winner selector: lowest-index first (mode 0) or first
// requester after the pointer with wrap-around (mode 1). Output is one-hot.
module rr_priority_select #(
  parameter int NUM_CH = 2,
  parameter int PTR_W  = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  input  logic              mode_i,
  output logic [NUM_CH-1:0] win_o,
  output logic [PTR_W-1:0]  win_idx_o
);

  logic found;

  always_comb begin
    win_o     = '0;
    win_idx_o = '0;
    found     = 1'b0;
    if (!mode_i) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (req_i[i] && !found) begin
          win_o[i]  = 1'b1;
          win_idx_o = PTR_W'(i);
          found     = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= NUM_CH; k++) begin
        int idx;
        idx = (int'(ptr_i) + k) % NUM_CH;
        if (req_i[idx] && !found) begin
          win_o[idx] = 1'b1;
          win_idx_o  = PTR_W'(idx);
          found      = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/register_port_arbiter.sv
// Arbitrates several requesters onto one register-file write/read port with
// a registered one-hot grant, bounded hold time and optional round-robin.
module register_port_arbiter
  import register_port_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int RR_MODE  = 0,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        we,
  input  logic [NUM_CH*ADDR_W-1:0] addr,
  input  logic [NUM_CH*DATA_W-1:0] wdata,
  output logic [NUM_CH-1:0]        grant,
  output logic [ADDR_W-1:0]        rf_addr,
  output logic                     rf_we,
  output logic [DATA_W-1:0]        rf_wdata,
  output logic                     busy,
  output arb_state_e               dbg_state
);

  localparam int PTR_W = $clog2(NUM_CH);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(clamp_hold(MAX_HOLD));
  localparam logic [PTR_W-1:0]  PTR_RST  = PTR_W'(NUM_CH - 1);

  arb_state_e        state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;

  logic [NUM_CH-1:0] sel_req;
  logic [NUM_CH-1:0] win;
  logic [PTR_W-1:0]  win_idx;
  logic              owner_req;
  logic              others;

  // The current owner is never a candidate: it only competes by keeping req.
  assign sel_req   = req & ~grant_q;
  assign owner_req = |(grant_q & req);
  assign others    = |sel_req;

  rr_priority_select #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_sel (
    .req_i     (sel_req),
    .ptr_i     (ptr_q),
    .mode_i    (RR_MODE != 0),
    .win_o     (win),
    .win_idx_o (win_idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      hold_q  <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (others) begin
          state_d = ST_OWN;
          grant_d = win;
          hold_d  = HOLD_W'(1);
          ptr_d   = win_idx;
        end
      end
      ST_OWN: begin
        if (owner_req) begin
          if (hold_q < HOLD_MAX) begin
            hold_d = hold_q + HOLD_W'(1);
          end else if (others) begin
            grant_d = win;
            hold_d  = HOLD_W'(1);
            ptr_d   = win_idx;
          end
        end else if (others) begin
          grant_d = win;
          hold_d  = HOLD_W'(1);
          ptr_d   = win_idx;
        end else begin
          state_d = ST_IDLE;
          grant_d = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // Port mux follows the live inputs of the owner, so mid-grant changes pass through.
  always_comb begin
    rf_addr  = '0;
    rf_we    = 1'b0;
    rf_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q[i] && req[i]) begin
        rf_addr  = addr[i*ADDR_W +: ADDR_W];
        rf_we    = we[i];
        rf_wdata = wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant     = grant_q;
  assign busy      = |grant_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_register_port_arbiter.sv
// Directed checks of the register port arbiter: a 2-channel fixed-priority
// instance and a 4-channel round-robin instance sharing clock and reset.
module tb_register_port_arbiter;
  import register_port_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]  f_req, f_we, f_grant;
  logic [9:0]  f_addr;
  logic [63:0] f_wdata;
  logic [4:0]  f_rf_addr;
  logic        f_rf_we, f_busy;
  logic [31:0] f_rf_wdata;
  arb_state_e  f_state;

  logic [3:0]   r_req, r_we, r_grant;
  logic [19:0]  r_addr;
  logic [127:0] r_wdata;
  logic [4:0]   r_rf_addr;
  logic         r_rf_we, r_busy;
  logic [31:0]  r_rf_wdata;
  arb_state_e   r_state;

  int n_checks = 0;
  int n_fail   = 0;

  register_port_arbiter #(.NUM_CH(2), .ADDR_W(5), .DATA_W(32), .RR_MODE(0), .MAX_HOLD(4)) u_fix (
    .clk(clk), .reset(reset), .req(f_req), .we(f_we), .addr(f_addr), .wdata(f_wdata),
    .grant(f_grant), .rf_addr(f_rf_addr), .rf_we(f_rf_we), .rf_wdata(f_rf_wdata),
    .busy(f_busy), .dbg_state(f_state)
  );

  register_port_arbiter #(.NUM_CH(4), .ADDR_W(5), .DATA_W(32), .RR_MODE(1), .MAX_HOLD(4)) u_rr (
    .clk(clk), .reset(reset), .req(r_req), .we(r_we), .addr(r_addr), .wdata(r_wdata),
    .grant(r_grant), .rf_addr(r_rf_addr), .rf_we(r_rf_we), .rf_wdata(r_rf_wdata),
    .busy(r_busy), .dbg_state(r_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    f_req = '0; r_req = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (f_grant !== 2'b00) begin n_fail++; $display("FAIL reset_grant got %b want 00", f_grant); end
    n_checks++; if (f_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", f_busy); end
    n_checks++; if (f_state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", f_state); end
    n_checks++; if (f_rf_we !== 1'b0 || f_rf_addr !== 5'd0 || f_rf_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rf got we=%b addr=%0d data=%h want zeros", f_rf_we, f_rf_addr, f_rf_wdata); end
    n_checks++; if (r_grant !== 4'b0000) begin n_fail++; $display("FAIL reset_rr_grant got %b want 0000", r_grant); end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    f_addr = {5'd9, 5'd3}; f_we = 2'b01; f_wdata = {32'hCAFE_0001, 32'h1111_2222};
    f_req = 2'b11;
    #1;
    n_checks++; if (f_rf_addr !== 5'd0 || f_rf_we !== 1'b0) begin
      n_fail++; $display("FAIL idle_rf got addr=%0d we=%b want 0/0", f_rf_addr, f_rf_we); end
    tick();
    n_checks++; if (f_grant !== 2'b01) begin n_fail++; $display("FAIL fixed_grant got %b want 01", f_grant); end
    n_checks++; if (f_rf_addr !== 5'd3 || f_rf_we !== 1'b1 || f_rf_wdata !== 32'h1111_2222) begin
      n_fail++; $display("FAIL fixed_rf got addr=%0d we=%b data=%h want 3/1/11112222", f_rf_addr, f_rf_we, f_rf_wdata); end
    n_checks++; if (f_busy !== 1'b1 || f_state !== ST_OWN) begin
      n_fail++; $display("FAIL fixed_busy got busy=%b state=%0d want 1/OWN", f_busy, f_state); end
  endtask

  task automatic test_hold_rotation();
    logic [1:0] exp;
    do_reset();
    f_req = 2'b11;
    for (int c = 1; c <= 12; c++) begin
      tick();
      exp = (((c - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      n_checks++; if (f_grant !== exp) begin n_fail++; $display("FAIL hold_rot cycle %0d got %b want %b", c, f_grant, exp); end
    end
  endtask

  task automatic test_write_path();
    do_reset();
    f_we = 2'b10; f_addr = {5'd7, 5'd0}; f_wdata = {32'hDEAD_BEEF, 32'h0};
    f_req = 2'b10;
    tick();
    n_checks++; if (f_grant !== 2'b10) begin n_fail++; $display("FAIL wr_grant got %b want 10", f_grant); end
    n_checks++; if (f_rf_we !== 1'b1 || f_rf_addr !== 5'd7 || f_rf_wdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL wr_rf got we=%b addr=%0d data=%h want 1/7/deadbeef", f_rf_we, f_rf_addr, f_rf_wdata); end
    f_addr = {5'd12, 5'd0};
    #1;
    n_checks++; if (f_rf_addr !== 5'd12) begin n_fail++; $display("FAIL wr_live_addr got %0d want 12", f_rf_addr); end
    f_req = 2'b00;
    #1;
    n_checks++; if (f_rf_we !== 1'b0 || f_rf_addr !== 5'd0) begin
      n_fail++; $display("FAIL wr_gate got we=%b addr=%0d want 0/0", f_rf_we, f_rf_addr); end
    tick();
    n_checks++; if (f_grant !== 2'b00 || f_busy !== 1'b0 || f_state !== ST_IDLE) begin
      n_fail++; $display("FAIL wr_release got grant=%b busy=%b state=%0d want 00/0/IDLE", f_grant, f_busy, f_state); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    f_req = 2'b10;
    tick();
    n_checks++; if (f_grant !== 2'b10) begin n_fail++; $display("FAIL rst_mid_pre got %b want 10", f_grant); end
    f_req = 2'b11; reset = 1'b1;
    tick();
    n_checks++; if (f_grant !== 2'b00 || f_busy !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_clear got grant=%b busy=%b want 00/0", f_grant, f_busy); end
    reset = 1'b0;
    tick();
    n_checks++; if (f_grant !== 2'b01) begin n_fail++; $display("FAIL rst_mid_resume got %b want 01", f_grant); end
  endtask

  task automatic test_sole_hold();
    do_reset();
    f_req = 2'b01;
    for (int c = 1; c <= 10; c++) begin
      tick();
      n_checks++; if (f_grant !== 2'b01) begin n_fail++; $display("FAIL sole_hold cycle %0d got %b want 01", c, f_grant); end
    end
    f_req = 2'b11;
    tick();
    n_checks++; if (f_grant !== 2'b10) begin n_fail++; $display("FAIL sole_sat_handover got %b want 10", f_grant); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    f_req = 2'b01;
    tick();
    f_req = 2'b10;
    tick();
    n_checks++; if (f_grant !== 2'b10 || f_state !== ST_OWN) begin
      n_fail++; $display("FAIL b2b got grant=%b state=%0d want 10/OWN", f_grant, f_state); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    r_we = 4'b0000; r_wdata = '0;
    r_addr = {5'd4, 5'd3, 5'd2, 5'd1};
    r_req = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      tick();
      n_checks++; if (r_grant !== exp_seq[s]) begin n_fail++; $display("FAIL rr_seq step %0d got %b want %b", s, r_grant, exp_seq[s]); end
      r_req = 4'b1111 & ~exp_seq[s];
    end
    r_req = 4'b1111;
    #1;
    n_checks++; if (r_rf_addr !== 5'd1) begin n_fail++; $display("FAIL rr_rf_addr got %0d want 1", r_rf_addr); end
  endtask

  initial begin
    reset = 1'b1;
    f_req = '0; f_we = '0; f_addr = '0; f_wdata = '0;
    r_req = '0; r_we = '0; r_addr = '0; r_wdata = '0;
    test_reset();
    test_fixed_priority();
    test_hold_rotation();
    test_write_path();
    test_reset_mid_grant();
    test_sole_hold();
    test_back_to_back();
    test_round_robin();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
